// File: rtl/skolem_seq_pkg.sv
// Shared types and helpers for the bit-serial bvsle(a | x, b) Skolem sequencer.
// Build option SKOLEM_SELFCHECK_EN (used in the top) enables the result self-check.
package skolem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SOLVE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEFAULT_W = 8;

  // Callers sign-extend their W-bit operands to this width first.
  localparam int SLE_W = 64;

  function automatic logic signed_le(input logic signed [SLE_W-1:0] y,
                                     input logic signed [SLE_W-1:0] b);
    return (y <= b);
  endfunction

endpackage

// File: rtl/skolem_bvsle_bvor_seq_bit_cell.sv
// One bit of the greedy MSB-first witness search: picks x_i and tracks whether
// the already-fixed prefix of (a | x) is strictly below b in signed order.
module skolem_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic is_msb,
  input  logic lt,
  input  logic ok_i,
  output logic x_i,
  output logic lt_next
);

  logic fallback_less;

  // With x_i = 0 the y bit is a_i; the MSB carries negative weight.
  assign fallback_less = is_msb ? (a_i & ~b_i) : (~a_i & b_i);

  always_comb begin
    x_i     = 1'b1;
    lt_next = 1'b1;
    if (!lt) begin
      if (is_msb && !b_i) begin
        x_i     = 1'b1;
        lt_next = 1'b1;
      end else if (b_i) begin
        x_i     = ok_i;
        lt_next = ok_i ? 1'b0 : fallback_less;
      end else begin
        x_i     = 1'b0;
        lt_next = fallback_less;
      end
    end
  end

endmodule

// File: rtl/skolem_bvsle_bvor_seq.sv
// Sequencer: LSB-first suffix scan, then MSB-first witness build via skolem_bit_cell.
// Define SKOLEM_SELFCHECK_EN to drive out_err from a check of the final result.
module skolem_bvsle_bvor_seq
  import skolem_seq_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic         out_sat,
  output logic         out_err,
  output logic         busy
);

  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, x_q, x_d, ok_q, ok_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          lt_q, lt_d, sat_q, sat_d;

  logic a_bit, b_bit, ok_bit, scan_ok, feasible, cell_x, cell_lt;

  assign a_bit   = a_q[idx_q];
  assign b_bit   = b_q[idx_q];
  assign ok_bit  = ok_q[idx_q];
  assign scan_ok = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & ok_bit);
  // Setting x_msb makes y negative, so only a negative b can be out of reach.
  assign feasible = ~b_q[W-1] | ok_q[W-1];

  skolem_bit_cell u_cell (
    .a_i    (a_bit),
    .b_i    (b_bit),
    .is_msb (idx_q == IDX_LAST),
    .lt     (lt_q),
    .ok_i   (ok_bit),
    .x_i    (cell_x),
    .lt_next(cell_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      ok_q    <= '0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      ok_q    <= ok_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    ok_d    = ok_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          x_d     = '0;
          sat_d   = 1'b0;
          lt_d    = 1'b0;
          ok_d    = '0;
          ok_d[0] = 1'b1;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == IDX_LAST) begin
          if (feasible) begin
            lt_d    = 1'b0;
            state_d = SOLVE;
          end else begin
            sat_d   = 1'b0;
            x_d     = '0;
            state_d = DONE;
          end
        end else begin
          ok_d[idx_q + 1'b1] = scan_ok;
          idx_d              = idx_q + 1'b1;
        end
      end
      SOLVE: begin
        x_d[idx_q] = cell_x;
        lt_d       = cell_lt;
        if (idx_q == '0) begin
          sat_d   = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_x     = x_q;
  assign out_sat   = sat_q;

`ifdef SKOLEM_SELFCHECK_EN
  assign out_err = (state_q == DONE) && sat_q &&
                   !signed_le(SLE_W'($signed(a_q | x_q)), SLE_W'($signed(b_q)));
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_skolem_bvsle_bvor_seq.sv
// Scoreboard bench: W=4 directed cases and W=8 random cases against a brute-force model.
module tb_skolem_bvsle_bvor_seq;
  import skolem_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv4, ir4, ov4, ordy4, sat4, err4, busy4;
  logic [3:0] a4, b4, x4;
  logic       iv8, ir8, ov8, ordy8, sat8, err8, busy8;
  logic [7:0] a8, b8, x8;

  skolem_bvsle_bvor_seq #(.W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .out_valid(ov4), .out_ready(ordy4), .out_x(x4), .out_sat(sat4), .out_err(err4),
    .busy(busy4)
  );

  skolem_bvsle_bvor_seq #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .out_valid(ov8), .out_ready(ordy8), .out_x(x8), .out_sat(sat8), .out_err(err8),
    .busy(busy8)
  );

  typedef struct {
    logic [7:0] x;
    logic       sat;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] sx(input logic [7:0] v, input int w);
    logic [3:0] lo;
    lo = v[3:0];
    return (w == 4) ? 64'($signed(lo)) : 64'($signed(v));
  endfunction

  // Brute force: the largest x wins because the loop runs upward.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.x   = '0;
    e.sat = 1'b0;
    for (int x = 0; x < (1 << w); x++) begin
      if (sx(a | 8'(x), w) <= sx(b, w)) begin
        e.sat = 1'b1;
        e.x   = 8'(x);
      end
    end
    e.lat = e.sat ? 2 * w + 1 : w + 1;
    return e;
  endfunction

  function automatic logic ovw(input int w);   return (w == 4) ? ov4 : ov8;     endfunction
  function automatic logic irw(input int w);   return (w == 4) ? ir4 : ir8;     endfunction
  function automatic logic busyw(input int w); return (w == 4) ? busy4 : busy8; endfunction
  function automatic logic satw(input int w);  return (w == 4) ? sat4 : sat8;   endfunction
  function automatic logic errw(input int w);  return (w == 4) ? err4 : err8;   endfunction
  function automatic logic [7:0] xw(input int w); return (w == 4) ? {4'b0, x4} : x8; endfunction

  task automatic set_in(input int w, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (w == 4) begin
      a4 = a[3:0]; b4 = b[3:0]; iv4 = v;
    end else begin
      a8 = a; b8 = b; iv8 = v;
    end
  endtask

  task automatic set_rdy(input int w, input logic v);
    if (w == 4) ordy4 = v; else ordy8 = v;
  endtask

  task automatic run(input int w, input logic [7:0] a, input logic [7:0] b, input int hold);
    exp_t e, g;
    int cnt;
    e = model(w, a, b);
    sb_q.push_back(e);
    chk("in_ready", irw(w), 1);
    set_in(w, 1'b1, a, b);
    @(posedge clk); #1;
    set_in(w, 1'b0, a, b);
    cnt = 1;
    while (!ovw(w) && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    g = sb_q.pop_front();
    chk("x", xw(w), g.x);
    chk("sat", satw(w), g.sat);
    chk("lat", cnt, g.lat);
    chk("err", errw(w), 0);
    if (g.sat) chk("sle", signed_le(sx(a | xw(w), w), sx(b, w)), 1);
    $display("txn w=%0d a=%h b=%h x=%h sat=%0d lat=%0d", w, a, b, xw(w), satw(w), cnt);
    for (int i = 0; i < hold; i++) begin
      set_in(w, 1'b1, ~a, ~b);
      @(posedge clk); #1;
      chk("hold_valid", ovw(w), 1);
      chk("hold_x", xw(w), g.x);
      chk("hold_ready", irw(w), 0);
    end
    set_in(w, 1'b0, a, b);
    set_rdy(w, 1'b1);
    @(posedge clk); #1;
    set_rdy(w, 1'b0);
    chk("idle_ready", irw(w), 1);
    chk("idle_valid", ovw(w), 0);
    if (hold > 0) begin
      @(posedge clk); #1;
      chk("no_queue", busyw(w), 0);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, ir4, 1);
    chk({tag, "_valid"}, ov4, 0);
    chk({tag, "_x"}, x4, 0);
    chk({tag, "_sat"}, sat4, 0);
    chk({tag, "_err"}, err4, 0);
    chk({tag, "_busy"}, busy4, 0);
  endtask

  initial begin
    iv4 = 0; a4 = 0; b4 = 0; ordy4 = 0;
    iv8 = 0; a8 = 0; b8 = 0; ordy8 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_reset("rst");
    chk("rst_ready8", ir8, 1);
    chk("rst_busy8", busy8, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run(4, 8'h01, 8'h0A, 0);   // sat, x=1001
    run(4, 8'h06, 8'h05, 0);   // y can go negative, x=1111
    run(4, 8'h03, 8'h0A, 0);   // unsat
    run(4, 8'h05, 8'h05, 0);
    run(4, 8'h08, 8'h08, 0);
    run(4, 8'h07, 8'h08, 10);  // unsat, held in DONE

    // Abort mid-SOLVE with an asynchronous reset.
    set_in(4, 1'b1, 8'h01, 8'h0A);
    @(posedge clk); #1;
    set_in(4, 1'b0, 8'h01, 8'h0A);
    repeat (6) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy4, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run(4, 8'h01, 8'h0A, 0);

    for (int i = 0; i < 40; i++) begin
      run(8, 8'($urandom), 8'($urandom), (i == 3) ? 3 : 0);
    end
    run(8, 8'h00, 8'h80, 0);
    run(8, 8'hFF, 8'h7F, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
